// File: rtl/uart_pkg.sv
// Shared UART register map, status bit positions and sequencer state encoding.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package uart_pkg;

    localparam logic [31:0] UART_CTRL   = 32'h0000_0000;
    localparam logic [31:0] UART_STATUS = 32'h0000_0004;
    localparam logic [31:0] UART_BAUD   = 32'h0000_0008;
    localparam logic [31:0] UART_TXDATA = 32'h0000_000C;
    localparam logic [31:0] UART_RXDATA = 32'h0000_0010;

    localparam logic [31:0] BAUD_115200 = 32'h0000_01B8;

    localparam int STAT_TX_BUSY = 0;
    localparam int STAT_RX_OVER = 1;

    typedef enum logic [2:0] {
        ST_INIT_BAUD,
        ST_INIT_CTRL,
        ST_POLL,
        ST_TX_WR,
        ST_RX_RD,
        ST_RX_CLR
    } seq_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the last-grant pointer advances only when i_take is high.
// Latency: grant is combinational from i_req; pointer updates on the next edge.
// Backpressure: none; the caller decides when a grant is consumed.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_take,
    output logic [1:0] o_gnt
);

    logic r_last1;

    always_comb begin
        o_gnt = i_req;
        if (i_req == 2'b11) begin
            o_gnt = r_last1 ? 2'b01 : 2'b10;
        end
    end

    // Reset to "requester 1 went last" so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last1 <= 1'b1;
        end else if (i_take && (o_gnt != 2'b00)) begin
            r_last1 <= o_gnt[1];
        end
    end

endmodule

// File: rtl/uart_tx_rx_seq.sv
// UART register sequencer: init baud/ctrl, then poll STATUS, serve RX (UART_SEQ_RX_EN) and arbitrated TX.
// Latency: one FSM state per clock; a TX byte is written one cycle after the POLL that sees TX idle.
// Backpressure: TX held off by STATUS busy; RX held in the UART while rx_valid_o waits for rx_ready_i.
module uart_tx_rx_seq
    import uart_pkg::*;
#(
    parameter logic [31:0] BAUD_DIV = BAUD_115200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid_i,
    input  logic [7:0]  req0_data_i,
    output logic        req0_ready_o,
    input  logic        req1_valid_i,
    input  logic [7:0]  req1_data_i,
    output logic        req1_ready_o,
    output logic        rx_valid_o,
    output logic [7:0]  rx_data_o,
    input  logic        rx_ready_i,
    output logic        uart_we_o,
    output logic [31:0] uart_addr_o,
    output logic [31:0] uart_wdata_o,
    input  logic [31:0] uart_rdata_i,
    output logic        init_done_o
);

`ifdef UART_SEQ_RX_EN
    localparam logic [31:0] CTRL_INIT = 32'h0000_0003;
`else
    localparam logic [31:0] CTRL_INIT = 32'h0000_0001;
`endif

    seq_state_t  r_state;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_rdy;
    logic        r_init_done;

    logic [1:0]  w_gnt;
    logic [7:0]  w_gnt_byte;
    logic        w_rx_go;
    logic        w_tx_go;

`ifdef UART_SEQ_RX_EN
    logic        r_rx_valid;
    logic [7:0]  r_rx_data;
    logic [23:0] w_unused_bits;

    assign w_unused_bits = uart_rdata_i[31:8];
    assign w_rx_go       = (r_state == ST_POLL) && uart_rdata_i[STAT_RX_OVER] && !r_rx_valid;
    assign rx_valid_o    = r_rx_valid;
    assign rx_data_o     = r_rx_data;
`else
    logic [30:0] w_unused_bits;

    assign w_unused_bits = {rx_ready_i, uart_rdata_i[31:2]};
    assign w_rx_go       = 1'b0;
    assign rx_valid_o    = 1'b0;
    assign rx_data_o     = 8'h00;
`endif

    assign w_tx_go    = (r_state == ST_POLL) && !w_rx_go && !uart_rdata_i[STAT_TX_BUSY]
                        && (req0_valid_i || req1_valid_i);
    assign w_gnt_byte = w_gnt[1] ? req1_data_i : req0_data_i;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_req  ({req1_valid_i, req0_valid_i}),
        .i_take (w_tx_go),
        .o_gnt  (w_gnt)
    );

    // Bus outputs are registered alongside the next state, so they never see req/rx_ready combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_INIT_BAUD;
            r_we        <= 1'b1;
            r_addr      <= UART_BAUD;
            r_wdata     <= BAUD_DIV;
            r_rdy       <= 2'b00;
            r_init_done <= 1'b0;
`ifdef UART_SEQ_RX_EN
            r_rx_valid  <= 1'b0;
            r_rx_data   <= 8'h00;
`endif
        end else begin
            r_we    <= 1'b0;
            r_addr  <= UART_STATUS;
            r_wdata <= 32'h0;
            r_rdy   <= 2'b00;
`ifdef UART_SEQ_RX_EN
            if (r_rx_valid && rx_ready_i) begin
                r_rx_valid <= 1'b0;
            end
`endif
            case (r_state)
                ST_INIT_BAUD: begin
                    r_state <= ST_INIT_CTRL;
                    r_we    <= 1'b1;
                    r_addr  <= UART_CTRL;
                    r_wdata <= CTRL_INIT;
                end
                ST_INIT_CTRL: begin
                    r_state     <= ST_POLL;
                    r_init_done <= 1'b1;
                end
                ST_POLL: begin
                    if (w_rx_go) begin
                        r_state <= ST_RX_RD;
                        r_addr  <= UART_RXDATA;
                    end else if (w_tx_go) begin
                        r_state <= ST_TX_WR;
                        r_we    <= 1'b1;
                        r_addr  <= UART_TXDATA;
                        r_wdata <= {24'h0, w_gnt_byte};
                        r_rdy   <= w_gnt;
                    end
                end
                ST_TX_WR: begin
                    r_state <= ST_POLL;
                end
`ifdef UART_SEQ_RX_EN
                ST_RX_RD: begin
                    r_state    <= ST_RX_CLR;
                    r_rx_data  <= uart_rdata_i[7:0];
                    r_rx_valid <= 1'b1;
                    r_we       <= 1'b1;
                end
                ST_RX_CLR: begin
                    r_state <= ST_POLL;
                end
`endif
                default: begin
                    r_state <= ST_INIT_BAUD;
                    r_we    <= 1'b1;
                    r_addr  <= UART_BAUD;
                    r_wdata <= BAUD_DIV;
                end
            endcase
        end
    end

    assign uart_we_o    = r_we;
    assign uart_addr_o  = r_addr;
    assign uart_wdata_o = r_wdata;
    assign init_done_o  = r_init_done;
    assign req0_ready_o = r_rdy[0] & req0_valid_i;
    assign req1_ready_o = r_rdy[1] & req1_valid_i;

endmodule

// File: tb/tb_uart_tx_rx_seq.sv
// Bench for uart_tx_rx_seq: a UART register model plus a round-robin scoreboard over random and directed traffic.
// Build with or without UART_SEQ_RX_EN; RX-specific steps follow the same macro.
module tb_uart_tx_rx_seq;

`ifdef UART_SEQ_RX_EN
    localparam logic [31:0] CTRL_EXP = 32'h3;
`else
    localparam logic [31:0] CTRL_EXP = 32'h1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req0_valid_i = 1'b0, req1_valid_i = 1'b0;
    logic [7:0]  req0_data_i = 8'h00, req1_data_i = 8'h00;
    logic        req0_ready_o, req1_ready_o;
    logic        rx_valid_o;
    logic [7:0]  rx_data_o;
    logic        rx_ready_i = 1'b0;
    logic        uart_we_o;
    logic [31:0] uart_addr_o, uart_wdata_o, uart_rdata_i;
    logic        init_done_o;

    int nvec = 0;
    int nerr = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] tx_log[$];
    int   busy_cnt = 0, busy_len = 0, last_w = 1, cyc = 0;
    int   rx_reads = 0, first_rd = -1, last_tx_cyc = -1;
    logic busy = 1'b0, busy_prev = 1'b0, rx_over = 1'b0, prev_strobe = 1'b0;
    logic [7:0] rx_byte = 8'h00;

    uart_tx_rx_seq #(.BAUD_DIV(32'h1B8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid_i(req0_valid_i), .req0_data_i(req0_data_i), .req0_ready_o(req0_ready_o),
        .req1_valid_i(req1_valid_i), .req1_data_i(req1_data_i), .req1_ready_o(req1_ready_o),
        .rx_valid_o(rx_valid_o), .rx_data_o(rx_data_o), .rx_ready_i(rx_ready_i),
        .uart_we_o(uart_we_o), .uart_addr_o(uart_addr_o), .uart_wdata_o(uart_wdata_o),
        .uart_rdata_i(uart_rdata_i), .init_done_o(init_done_o)
    );

    always #5 clk = ~clk;

    // UART register file as seen by the sequencer.
    always_comb begin
        uart_rdata_i = 32'h0;
        if (uart_addr_o == 32'h4)       uart_rdata_i = {30'h0, rx_over, busy};
        else if (uart_addr_o == 32'h10) uart_rdata_i = {24'h0, rx_byte};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        req0_valid_i = (q0.size() > 0);
        req0_data_i  = (q0.size() > 0) ? q0[0] : 8'h00;
        req1_valid_i = (q1.size() > 0);
        req1_data_i  = (q1.size() > 0) ? q1[0] : 8'h00;
    endtask

    // One clock: observe at the falling edge, score, update the UART model, present next requester data.
    task automatic tick();
        logic       txw;
        logic [1:0] exp_rdy;
        logic [7:0] expb;
        int         w;
        @(negedge clk);
        cyc++;
        txw     = uart_we_o && (uart_addr_o == 32'hC);
        exp_rdy = 2'b00;
        if (txw) begin
            if (q0.size() == 0 && q1.size() == 0) begin
                chk("tx_spurious", {31'h0, txw}, 32'h0);
            end else begin
                if (q0.size() > 0 && q1.size() > 0) w = (last_w == 0) ? 1 : 0;
                else w = (q0.size() > 0) ? 0 : 1;
                expb = (w == 0) ? q0[0] : q1[0];
                chk("tx_byte", uart_wdata_o, {24'h0, expb});
                chk("tx_while_busy", {31'h0, busy_prev}, 32'h0);
                exp_rdy = (w == 0) ? 2'b01 : 2'b10;
                if (w == 0) void'(q0.pop_front());
                else void'(q1.pop_front());
                last_w = w;
                tx_log.push_back(uart_wdata_o[7:0]);
                last_tx_cyc = cyc;
                busy_cnt = busy_len;
            end
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        chk("ready", {30'h0, req1_ready_o, req0_ready_o}, {30'h0, exp_rdy});
        if (prev_strobe) chk("we_gap", {31'h0, uart_we_o}, 32'h0);
        prev_strobe = uart_we_o && (uart_addr_o == 32'hC || uart_addr_o == 32'h4);
        if (!uart_we_o && uart_addr_o == 32'h10) begin
            rx_reads++;
            if (first_rd < 0) first_rd = cyc;
        end
        if (uart_we_o && uart_addr_o == 32'h4 && uart_wdata_o == 32'h0) rx_over = 1'b0;
        busy      = (busy_cnt > 0);
        busy_prev = busy;
        drive();
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || busy) && n < maxc) begin
            tick();
            n++;
        end
        chk("drain_left", q0.size() + q1.size(), 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_we"}, {31'h0, uart_we_o}, 32'h1);
        chk({tag, "_addr"}, uart_addr_o, 32'h8);
        chk({tag, "_wdata"}, uart_wdata_o, 32'h1B8);
        chk({tag, "_init"}, {31'h0, init_done_o}, 32'h0);
        chk({tag, "_rdy"}, {30'h0, req1_ready_o, req0_ready_o}, 32'h0);
        chk({tag, "_rxv"}, {31'h0, rx_valid_o}, 32'h0);
        chk({tag, "_rxd"}, {24'h0, rx_data_o}, 32'h0);
    endtask

    task automatic release_and_check_init();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("c1_we", {31'h0, uart_we_o}, 32'h1);
        chk("c1_addr", uart_addr_o, 32'h8);
        chk("c1_wdata", uart_wdata_o, 32'h1B8);
        tick();
        chk("c2_we", {31'h0, uart_we_o}, 32'h1);
        chk("c2_addr", uart_addr_o, 32'h0);
        chk("c2_wdata", uart_wdata_o, CTRL_EXP);
        chk("c2_init", {31'h0, init_done_o}, 32'h0);
        tick();
        chk("c3_init", {31'h0, init_done_o}, 32'h1);
        chk("c3_addr", uart_addr_o, 32'h4);
        chk("c3_we", {31'h0, uart_we_o}, 32'h0);
    endtask

    initial begin
        int n;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst");
        @(negedge clk);
        release_and_check_init();

        // Both requesters pending from reset: requester 0 wins the first tie.
        busy_len = 2;
        q0.push_back(8'hA0); q0.push_back(8'hA0);
        q1.push_back(8'hB1); q1.push_back(8'hB1);
        tx_log.delete();
        drive();
        drain(60);
        chk("alt_n", tx_log.size(), 32'd4);
        if (tx_log.size() == 4) begin
            chk("alt_0", {24'h0, tx_log[0]}, 32'hA0);
            chk("alt_1", {24'h0, tx_log[1]}, 32'hB1);
            chk("alt_2", {24'h0, tx_log[2]}, 32'hA0);
            chk("alt_3", {24'h0, tx_log[3]}, 32'hB1);
        end

        // Single requester with a long busy window between bytes.
        busy_len = 10;
        tx_log.delete();
        q0.push_back(8'h55); q0.push_back(8'h56);
        drive();
        drain(80);
        chk("single_n", tx_log.size(), 32'd2);

`ifdef UART_SEQ_RX_EN
        rx_byte = 8'h7E; rx_over = 1'b1; busy_cnt = 3; busy = 1'b1; busy_len = 0;
        rx_reads = 0; first_rd = -1; last_tx_cyc = -1;
        q0.push_back(8'h33);
        drive();
        repeat (20) tick();
        chk("rx_reads1", rx_reads, 32'd1);
        chk("rx_valid1", {31'h0, rx_valid_o}, 32'h1);
        chk("rx_data1", {24'h0, rx_data_o}, 32'h7E);
        chk("rx_cleared", {31'h0, rx_over}, 32'h0);
        chk("rx_before_tx", {31'h0, (first_rd >= 0) && (first_rd < last_tx_cyc)}, 32'h1);
        rx_over = 1'b1; rx_byte = 8'h99;
        n = rx_reads;
        repeat (15) tick();
        chk("rx_held_reads", rx_reads, n);
        chk("rx_held_data", {24'h0, rx_data_o}, 32'h7E);
        chk("rx_held_valid", {31'h0, rx_valid_o}, 32'h1);
        rx_ready_i = 1'b1;
        tick();
        rx_ready_i = 1'b0;
        repeat (6) tick();
        chk("rx_reads2", rx_reads, n + 1);
        chk("rx_data2", {24'h0, rx_data_o}, 32'h99);
        rx_ready_i = 1'b1;
        tick();
        tick();
        rx_ready_i = 1'b0;
        chk("rx_valid_clr", {31'h0, rx_valid_o}, 32'h0);
`endif

        // Random bursts with random busy windows, scored against the round-robin model.
        for (int r = 0; r < 30; r++) begin
            busy_len = $urandom_range(0, 4);
            for (int k = $urandom_range(0, 4); k > 0; k--) q0.push_back(8'($urandom_range(0, 255)));
            for (int k = $urandom_range(0, 4); k > 0; k--) q1.push_back(8'($urandom_range(0, 255)));
            drive();
            drain(200);
        end
`ifndef UART_SEQ_RX_EN
        chk("norx_valid", {31'h0, rx_valid_o}, 32'h0);
        chk("norx_data", {24'h0, rx_data_o}, 32'h0);
`endif

        // Reset arriving during the TXDATA write abandons the byte and re-runs init.
        busy_len = 0;
        q0.push_back(8'h5A);
        drive();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(uart_we_o && uart_addr_o == 32'hC) && n < 20);
        chk("txwr_seen", {31'h0, uart_we_o && uart_addr_o == 32'hC}, 32'h1);
        rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        last_w = 1; busy_cnt = 0; busy = 1'b0; busy_prev = 1'b0; prev_strobe = 1'b0; rx_over = 1'b0;
        @(negedge clk);
        release_and_check_init();
        tx_log.delete();
        drain(30);
        chk("retx_n", tx_log.size(), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
